// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU result writeback block: FSM states,
// ALU select encodings and select classification helpers.
package alu_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WB_LO = 2'd1,
      ST_WB_HI = 2'd2
   } wb_state_t;

   localparam logic [3:0] SEL_ADD = 4'd1;
   localparam logic [3:0] SEL_SUB = 4'd2;
   localparam logic [3:0] SEL_AND = 4'd3;
   localparam logic [3:0] SEL_OR  = 4'd4;
   localparam logic [3:0] SEL_XOR = 4'd5;
   localparam logic [3:0] SEL_NOT = 4'd6;
   localparam logic [3:0] SEL_SHL = 4'd7;
   localparam logic [3:0] SEL_SHR = 4'd8;
   localparam logic [3:0] SEL_ROR = 4'd9;
   localparam logic [3:0] SEL_ROL = 4'd10;
   localparam logic [3:0] SEL_DIV = 4'd11;
   localparam logic [3:0] SEL_MUL = 4'd12;

   // DIV and MUL produce a meaningful upper half and need a second beat.
   function automatic logic is_wide(input logic [3:0] sel);
      return (sel == SEL_DIV) || (sel == SEL_MUL);
   endfunction

   function automatic logic is_legal(input logic [3:0] sel);
      return (sel >= SEL_ADD) && (sel <= SEL_MUL);
   endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative flag computation for a captured ALU result.
// MUL flags look at the full double-width product; all other ops use LO.
module alu_flag_gen
   import alu_wb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2*DATA_W-1:0] i_result,
   input  logic [3:0]          i_select,
   output logic                o_z,
   output logic                o_n
);

   logic w_full;

   assign w_full = (i_select == SEL_MUL);

   // Pick the flag source width based on the op.
   always_comb begin
      o_z = 1'b0;
      o_n = 1'b0;
      if (w_full) begin
         o_z = (i_result == '0);
         o_n = i_result[2*DATA_W-1];
      end else begin
         o_z = (i_result[DATA_W-1:0] == '0);
         o_n = i_result[DATA_W-1];
      end
   end

endmodule

// File: rtl/alu_result_writeback.sv
// ALU result writeback: latches an ALU result on capture and writes LO (and
// HI for DIV/MUL) to the register file over a valid/ready handshake.
// Optional flag outputs z_flag/n_flag are built when ALU_WB_FLAGS_EN is defined.
module alu_result_writeback
   import alu_wb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic [2*DATA_W-1:0] alu_result,
   input  logic [3:0]          alu_select,
   input  logic                capture,
   output logic                busy,
   output logic [DATA_W-1:0]   zlo,
   output logic [DATA_W-1:0]   zhi,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [DATA_W-1:0]   wb_data,
   output logic                wb_dest,
   output logic                done,
   output logic                illegal
`ifdef ALU_WB_FLAGS_EN
   ,
   output logic                z_flag,
   output logic                n_flag
`endif
);

   wb_state_t         r_state, w_next;
   logic [DATA_W-1:0] r_zlo, r_zhi;
   logic              r_wide, r_done, r_illegal;
   logic              w_accept, w_reject, w_last;

   // Next state and handshake outputs; capture only looked at in IDLE.
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_reject = 1'b0;
      w_last   = 1'b0;
      busy     = 1'b0;
      wb_valid = 1'b0;
      wb_data  = '0;
      wb_dest  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (capture) begin
               if (is_legal(alu_select)) begin
                  w_accept = 1'b1;
                  w_next   = ST_WB_LO;
               end else begin
                  w_reject = 1'b1;
               end
            end
         end
         ST_WB_LO: begin
            busy     = 1'b1;
            wb_valid = 1'b1;
            wb_data  = r_zlo;
            if (wb_ready) begin
               if (r_wide) begin
                  w_next = ST_WB_HI;
               end else begin
                  w_next = ST_IDLE;
                  w_last = 1'b1;
               end
            end
         end
         ST_WB_HI: begin
            busy     = 1'b1;
            wb_valid = 1'b1;
            wb_data  = r_zhi;
            wb_dest  = 1'b1;
            if (wb_ready) begin
               w_next = ST_IDLE;
               w_last = 1'b1;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!clr_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Result registers; HI is cleared for narrow ops so it never shows stale data.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_zlo  <= '0;
         r_zhi  <= '0;
         r_wide <= 1'b0;
      end else if (w_accept) begin
         r_zlo  <= alu_result[DATA_W-1:0];
         r_zhi  <= is_wide(alu_select) ? alu_result[2*DATA_W-1:DATA_W] : '0;
         r_wide <= is_wide(alu_select);
      end
   end

   // One-cycle status pulses.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_done    <= w_last;
         r_illegal <= w_reject;
      end
   end

   assign zlo     = r_zlo;
   assign zhi     = r_zhi;
   assign done    = r_done;
   assign illegal = r_illegal;

`ifdef ALU_WB_FLAGS_EN
   logic w_z, w_n, r_z, r_n;

   alu_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
      .i_result (alu_result),
      .i_select (alu_select),
      .o_z      (w_z),
      .o_n      (w_n)
   );

   // Flags follow every legal capture and hold otherwise.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_z <= 1'b0;
         r_n <= 1'b0;
      end else if (w_accept) begin
         r_z <= w_z;
         r_n <= w_n;
      end
   end

   assign z_flag = r_z;
   assign n_flag = r_n;
`endif

endmodule

// File: tb/tb_alu_result_writeback.sv
// Bench for alu_result_writeback: directed vector table, stall/reset
// sequences and random traffic against a beat-queue reference model.
module tb_alu_result_writeback;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          clr_n, capture, wb_ready;
   logic [63:0]   alu_result;
   logic [3:0]    alu_select;
   logic          busy, wb_valid, wb_dest, done, illegal;
   logic [DW-1:0] zlo, zhi, wb_data;
`ifdef ALU_WB_FLAGS_EN
   logic          z_flag, n_flag;
`endif

   always #5 clk = ~clk;

   alu_result_writeback #(.DATA_W(DW)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .alu_result (alu_result),
      .alu_select (alu_select),
      .capture    (capture),
      .busy       (busy),
      .zlo        (zlo),
      .zhi        (zhi),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_data    (wb_data),
      .wb_dest    (wb_dest),
      .done       (done),
      .illegal    (illegal)
`ifdef ALU_WB_FLAGS_EN
      ,
      .z_flag     (z_flag),
      .n_flag     (n_flag)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: pending register-file writes as a queue of beats.
   typedef struct {
      logic [DW-1:0] data;
      logic          dest;
   } beat_t;

   beat_t         mq[$];
   logic [DW-1:0] m_zlo = '0, m_zhi = '0;
   logic          m_done = 1'b0, m_ill = 1'b0, m_z = 1'b0, m_n = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input logic cap, input logic [3:0] sel,
                               input logic [63:0] res, input logic rdy, input logic rst_n);
      logic nd, ni;
      beat_t b;
      nd = 1'b0;
      ni = 1'b0;
      if (!rst_n) begin
         mq.delete();
         m_zlo = '0; m_zhi = '0; m_z = 1'b0; m_n = 1'b0;
      end else if (mq.size() > 0) begin
         if (rdy) begin
            void'(mq.pop_front());
            if (mq.size() == 0) nd = 1'b1;
         end
      end else if (cap) begin
         if (sel >= 1 && sel <= 12) begin
            m_zlo = res[31:0];
            m_zhi = (sel >= 11) ? res[63:32] : 32'd0;
            b.data = m_zlo; b.dest = 1'b0; mq.push_back(b);
            if (sel >= 11) begin
               b.data = m_zhi; b.dest = 1'b1; mq.push_back(b);
            end
            if (sel == 12) begin
               m_z = (res == 64'd0); m_n = res[63];
            end else begin
               m_z = (res[31:0] == 32'd0); m_n = res[31];
            end
         end else begin
            ni = 1'b1;
         end
      end
      m_done = nd;
      m_ill  = ni;
   endtask

   task automatic check_all();
      chk("busy", busy, mq.size() > 0);
      chk("wb_valid", wb_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("wb_data", wb_data, mq[0].data);
         chk("wb_dest", wb_dest, mq[0].dest);
      end
      chk("done", done, m_done);
      chk("illegal", illegal, m_ill);
      chk("zlo", zlo, m_zlo);
      chk("zhi", zhi, m_zhi);
`ifdef ALU_WB_FLAGS_EN
      chk("z_flag", z_flag, m_z);
      chk("n_flag", n_flag, m_n);
`endif
   endtask

   // Drive at negedge, clock one edge, advance the model, check at negedge.
   task automatic step(input logic cap, input logic [3:0] sel, input logic [63:0] res,
                       input logic rdy, input logic rst_n);
      capture = cap; alu_select = sel; alu_result = res; wb_ready = rdy; clr_n = rst_n;
      @(posedge clk);
      model_update(cap, sel, res, rdy, rst_n);
      @(negedge clk);
      check_all();
   endtask

   typedef struct {
      logic [3:0]  sel;
      logic [63:0] res;
      int          nbeats;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        ill;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int          cnt, done_at;
      logic        seen_ill;
      logic [31:0] obs[2];

      tbl[0] = '{4'd1,  64'h0000_0000_0000_0005, 1, 32'h0000_0005, 32'h0,         1'b0};
      tbl[1] = '{4'd12, 64'h0000_0001_FFFF_FFFE, 2, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      tbl[2] = '{4'd11, 64'h0000_0003_0000_0007, 2, 32'h0000_0007, 32'h0000_0003, 1'b0};
      tbl[3] = '{4'd10, 64'hDEAD_BEEF_1234_5678, 1, 32'h1234_5678, 32'h0,         1'b0};
      tbl[4] = '{4'd0,  64'h1111_2222_3333_4444, 0, 32'h1234_5678, 32'h0,         1'b1};
      tbl[5] = '{4'd14, 64'h5555_6666_7777_8888, 0, 32'h1234_5678, 32'h0,         1'b1};

      capture = 1'b0; alu_select = '0; alu_result = '0; wb_ready = 1'b0; clr_n = 1'b0;
      @(negedge clk);
      step(1'b1, 4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      step(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_dest", wb_dest, 0);

      // Directed vector table, wb_ready held high.
      foreach (tbl[v]) begin
         cnt = 0; done_at = -1; seen_ill = 1'b0; obs[0] = '0; obs[1] = '0;
         step(1'b1, tbl[v].sel, tbl[v].res, 1'b1, 1'b1);
         for (int k = 0; k < 4; k++) begin
            if (wb_valid && cnt < 2) begin
               obs[cnt] = wb_data;
               cnt++;
            end
            if (done && done_at < 0) done_at = k;
            if (illegal) seen_ill = 1'b1;
            step(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
         end
         chk($sformatf("vec%0d_nbeats", v), cnt, tbl[v].nbeats);
         if (tbl[v].nbeats > 0) chk($sformatf("vec%0d_lo_beat", v), obs[0], tbl[v].lo);
         if (tbl[v].nbeats > 1) chk($sformatf("vec%0d_hi_beat", v), obs[1], tbl[v].hi);
         chk($sformatf("vec%0d_done_cycle", v), done_at, (tbl[v].nbeats > 0) ? tbl[v].nbeats : -1);
         chk($sformatf("vec%0d_illegal", v), seen_ill, tbl[v].ill);
         chk($sformatf("vec%0d_zlo", v), zlo, tbl[v].lo);
         chk($sformatf("vec%0d_zhi", v), zhi, tbl[v].hi);
      end

      // Stall on LO for 5 cycles with an extra capture mid-stall.
      step(1'b1, 4'd11, 64'h0000_0009_0000_0042, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(i == 2, 4'd1, 64'h0000_0000_0000_0077, 1'b0, 1'b1);
         chk("stall_valid", wb_valid, 1);
         chk("stall_data", wb_data, 32'h42);
         chk("stall_dest", wb_dest, 0);
         chk("stall_zlo", zlo, 32'h42);
      end
      step(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
      chk("stall_hi_data", wb_data, 32'h9);
      step(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
      chk("stall_done", done, 1);

      // Reset during WB_HI of a MUL, then a clean narrow op.
      step(1'b1, 4'd12, 64'h0000_00AA_0000_00BB, 1'b1, 1'b1);
      step(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
      chk("abort_in_hi", wb_dest, 1);
      step(1'b0, 4'd0, 64'd0, 1'b1, 1'b0);
      chk("abort_valid", wb_valid, 0);
      chk("abort_zlo", zlo, 0);
      chk("abort_zhi", zhi, 0);
      chk("abort_done", done, 0);
      step(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
      chk("abort_no_done", done, 0);
      step(1'b1, 4'd3, 64'h0000_0000_0000_0005, 1'b1, 1'b1);
      chk("post_rst_data", wb_data, 32'h5);
      step(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
      chk("post_rst_done", done, 1);

`ifdef ALU_WB_FLAGS_EN
      step(1'b1, 4'd2, 64'h0000_0000_8000_0000, 1'b1, 1'b1);
      chk("flag_n_narrow", n_flag, 1);
      chk("flag_z_narrow", z_flag, 0);
      step(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
      step(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
      step(1'b1, 4'd12, 64'd0, 1'b1, 1'b1);
      chk("flag_z_mul", z_flag, 1);
      chk("flag_n_mul", n_flag, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 64'd0, 1'b1, 1'b1);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic [63:0] r;
         r = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: r = 64'd0;
            1: r = {32'd0, r[31:0]};
            default: ;
         endcase
         step(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), r,
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_result_writeback.md
ALU_RESULT_WRITEBACK -- requirements
Module: alu_result_writeback

Interface
REQ-001 Parameter DATA_W, default 32, word width of each writeback beat; ALU result width is 2*DATA_W.
REQ-002 clk  in  1  single clock, all state changes on rising edge.
REQ-003 clr_n  in  1  reset, synchronous, active-low.
REQ-004 alu_result  in  2*DATA_W  ALU output; [DATA_W-1:0]=LO (quotient/low product), upper half=HI (remainder/high product).
REQ-005 alu_select  in  4  opcode presented to ALU with this result; 1..10 narrow ops, 11 DIV, 12 MUL.
REQ-006 capture  in  1  strobe: latch alu_result/alu_select this cycle.
REQ-007 busy  out  1  high while a writeback sequence is in progress.
REQ-008 zlo / zhi  out  DATA_W each  held LO/HI result registers.
REQ-009 wb_valid  out  1; wb_ready  in  1; wb_data  out  DATA_W; wb_dest  out  1 (0=LO, 1=HI): register-file write handshake.
REQ-010 done  out  1  one-cycle pulse after final beat accepted.
REQ-011 illegal  out  1  one-cycle pulse on capture with unsupported select.

Function
REQ-012 FSM states IDLE, WB_LO, WB_HI; busy=1 in WB_LO and WB_HI only.
REQ-013 IDLE, capture=1, select 1..12: zlo<=result[DATA_W-1:0], zhi<=upper half if select 11/12 else 0, latch wide flag, go WB_LO.
REQ-014 IDLE, capture=1, select 0 or 13..15: zlo/zhi unchanged, stay IDLE, illegal=1 next cycle.
REQ-015 capture while busy=1 (including the cycle of the final handshake) is ignored, no illegal pulse.
REQ-016 WB_LO: wb_valid=1, wb_data=zlo, wb_dest=0; on wb_ready=1 go WB_HI if wide else IDLE.
REQ-017 WB_HI: wb_valid=1, wb_data=zhi, wb_dest=1; on wb_ready=1 go IDLE.
REQ-018 wb_valid, wb_data, wb_dest held stable while wb_valid=1 and wb_ready=0; no timeout.
REQ-019 Latency: capture sampled at edge N, wb_valid=1 in cycle after N; wb_ready tied high gives narrow op done in cycle N+2, wide op done in N+3.
REQ-020 done=1 for exactly one cycle following the edge that accepts the last beat; wb_valid=0 in IDLE.
REQ-021 zlo/zhi hold value after sequence until next legal capture.

Reset
REQ-022 clr_n=0 at an edge: state IDLE, zlo=zhi=0, wb_valid=0, wb_data=0, wb_dest=0, busy=0, done=0, illegal=0, flags 0; overrides capture and any in-flight beat.
REQ-023 Reset mid-sequence aborts without done pulse; first capture after release accepted normally.

Configuration
REQ-024 Macro ALU_WB_FLAGS_EN defined: outputs z_flag and n_flag (1 bit each) exist, updated on every legal capture, reset 0.
REQ-025 With flags: narrow/DIV z_flag=(LO==0), n_flag=LO[DATA_W-1]; MUL z_flag=(full 2*DATA_W result==0), n_flag=result[2*DATA_W-1].
REQ-026 Macro undefined: z_flag/n_flag ports and logic absent; all other behaviour identical.

Structure
REQ-027 Shared package alu_wb_pkg: FSM state enum, select constants SEL_ADD=1..SEL_ROL=10, SEL_DIV=11, SEL_MUL=12, is_wide(select) function.
REQ-028 One sub-module alu_flag_gen (combinational flag computation), instantiated only under ALU_WB_FLAGS_EN.

Verification
REQ-029 Reset then capture, select=1, result=64'h0000_0000_0000_0005, wb_ready=1 -> one beat wb_data=5 dest=0, done pulse, zhi=0.
REQ-030 Capture select=12, result=64'h0000_0001_FFFF_FFFE, wb_ready=1 -> beats LO=FFFF_FFFE then HI=0000_0001, done one cycle after HI.
REQ-031 Capture select=11, wb_ready=0 for 5 cycles -> wb_valid/wb_data/wb_dest stable on LO; second capture during stall ignored, zlo unchanged.
REQ-032 Capture select=0 and select=14 -> illegal pulse each, busy stays 0, no wb_valid.
REQ-033 clr_n=0 during WB_HI of select=12 -> next cycle wb_valid=0, zlo=zhi=0, no done; new capture select=3 completes normally.
REQ-034 ALU_WB_FLAGS_EN: select=2, result LO=32'h8000_0000 -> n_flag=1, z_flag=0; select=12, result=0 -> z_flag=1, n_flag=0.
